cic_dsm_decimator: RTL and testbench
====================================

# cic_dsm_decimator

Reconstructs multi-bit PCM samples from a delta-sigma stream: the receive-side counterpart of the NCO → MASH 1-1 → second-order modulator chain. Accepts either the signed multi-bit MASH output or the 1-bit modulator bitstream on an AXI-Stream slave. Runs it through an N-stage CIC decimator (order 3, ratio 16 by default) and emits one signed sample per R accepted inputs on an AXI-Stream master. Used in loopback benches and on-chip monitors to recover the NCO waveform.

## Interface
- IN_WIDTH, 4: input width. Values ≥ 2 are signed two's complement. Value 1 selects bitstream mode: 1 → +1, 0 → −1.
- OUT_WIDTH, 16: output sample width, signed.
- N, 3: CIC order, i.e. the number of integrator and comb stages. Range 1..5.
- R, 16: decimation ratio, a power of two, 2..256.
- aclk  in  1  clock, one clock domain.
- arst_n  in  1  synchronous, active-low reset.
- s_axis_data_tdata  in  IN_WIDTH  modulator sample.
- s_axis_data_tvalid  in  1  input sample valid.
- s_axis_data_tready  out  1  block can accept a beat.
- m_axis_data_tdata  out  OUT_WIDTH  decimated signed sample.
- m_axis_data_tvalid  out  1  output sample valid.
- m_axis_data_tready  in  1  downstream accepts.

## Operation
- Effective input width EW = max(IN_WIDTH, 2). The input is sign-extended to ACC_WIDTH = EW + N·log2(R); the default is 16.
- Accepted beat: s_tvalid & s_tready.
- On every accepted beat:
  - All integrators update in parallel from pre-update values: I1 ← I1 + x, Ik ← Ik + I(k−1).
  - The phase counter cnt (0..R−1) increments and wraps.
- Integrators and combs use modular ACC_WIDTH arithmetic. Wrap-around is intentional, is never saturated, and is exact by CIC property.
- Decimation event: an accepted beat while cnt == R−1. On the same clock the comb chain evaluates on the pre-update value of I_N:
  - C1 = I_N − D1, then Ck = C(k−1) − Dk.
  - Each Dk ← its stage input.
  - The output register ← C_N scaled.
- Scaling:
  - If OUT_WIDTH ≥ ACC_WIDTH, sign-extend.
  - Otherwise take the top OUT_WIDTH bits (truncation toward −∞).
- DC gain is R^N = 4096 at default parameters. Constant input x settles to x·4096.
- Integrators do not advance without an accepted beat.
- s_tready = !(m_tvalid & !m_tready & cnt == R−1). Input stalls only when the next beat would overwrite an undelivered output.

## Timing
- Reset (arst_n low at a rising edge) clears I1..IN, D1..DN, cnt, the output register and m_tvalid to 0.
- s_tready reads 1 while the block is idle. Beats presented while arst_n = 0 are ignored.
- Latency: m_tvalid rises on the clock after the decimation-event edge, together with the new tdata.
- m_tvalid holds, and tdata is stable, until a cycle with m_tready = 1. It then clears unless the same edge is itself a decimation event; in that case it stays 1 with the new data, giving back-to-back delivery.
- Simultaneous decimation event and output handshake on one edge: the new sample loads, m_tvalid stays 1, and no sample is lost or duplicated.
- Throughput: one input per clock sustained when the downstream never stalls.
- Reset mid-operation: all state clears on that edge, and any partially integrated window is discarded. The first output after reset comes R accepted beats later.
- Transient: outputs 1..N contain a settling response. From output N+2 onward, a constant input yields exactly x·R^N.

## Structure
- Shared package cic_pkg:
  - function cic_acc_width(in_w, n, r)
  - localparam defaults (N, R)
  - function for the bitstream-to-±1 mapping
- Sub-module cic_comb_stage: one registered delay plus subtractor with an enable.
- Integrators are a generate loop in the top module.
- Top module holds the counter, handshake, output register and scaling.

## Test plan
- IN_WIDTH=4, constant +1 for 128 beats, m_tready=1 → outputs 5..8 are each 4096. Exactly 8 outputs, spaced 16 clocks apart.
- Constant −8 for 128 beats → steady outputs −32768. Constant +7 → 28672. No overflow artefacts.
- IN_WIDTH=1 bitstream, all ones → steady 4096 (sign-extended from 14 bits). Alternating 1,0 → steady 0.
- Backpressure: hold m_tready=0 from output 3 onward → s_tready drops exactly when cnt == 15. No input is consumed while it is low. Releasing m_tready delivers the held sample unchanged, then resumes.
- Gapped s_tvalid (random 50%), constant +2 → steady outputs 8192. One output per 16 accepted beats regardless of gaps.
- Reset asserted for one clock at beat 40 of a +1 stream → m_tvalid 0 the next cycle. The next output arrives 16 accepted beats after reset release, and the value sequence restarts as from cold.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC delta-sigma decimator.
// Provides accumulator sizing and the bitstream-to-(+/-1) mapping.
package cic_pkg;

   // Default filter shape: third order, decimate by 16.
   localparam int CIC_N_DEF = 3;
   localparam int CIC_R_DEF = 16;

   // Smallest signed value that can carry +1 and -1.
   localparam int CIC_MIN_EW = 2;

   typedef logic signed [CIC_MIN_EW-1:0] cic_pm1_t;

   // Effective input width: a 1-bit stream is widened to a
   // 2-bit signed value so that it can represent -1.
   function automatic int cic_eff_width(input int in_w);
      return (in_w < CIC_MIN_EW) ? CIC_MIN_EW : in_w;
   endfunction

   // Bit growth of an order-n, ratio-r CIC is n*log2(r) bits;
   // this width makes modular wrap-around in the integrators exact.
   function automatic int cic_acc_width(
      input int in_w,
      input int n,
      input int r
   );
      return cic_eff_width(in_w) + n * $clog2(r);
   endfunction

   // Modulator bitstream: 1 means +1, 0 means -1.
   function automatic cic_pm1_t cic_bit_to_pm1(input logic b);
      return b ? 2'sb01 : 2'sb11;
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x(previous decimation event).
// Ports: i_clk, i_rst_n (sync, active low), i_en (decimation strobe),
//        i_x (stage input), o_y (combinational difference).
module cic_comb_stage #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic [W-1:0] i_x,
   output logic [W-1:0] o_y
);

   logic [W-1:0] r_dly;

   // The delay only moves on decimation events, so it holds the
   // stage input from exactly one output period ago.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_dly <= '0;
      end else if (i_en) begin
         r_dly <= i_x;
      end
   end

   // Modular subtraction; wrap-around cancels the integrator wrap.
   assign o_y = i_x - r_dly;

endmodule

// File: rtl/cic_dsm_decimator.sv
// CIC decimator that rebuilds PCM samples from a delta-sigma stream.
// Ports: aclk, arst_n (sync, active low);
//        s_axis_data_* : AXI-Stream slave, modulator samples in
//                        (IN_WIDTH=1 selects 1-bit bitstream mode);
//        m_axis_data_* : AXI-Stream master, one signed sample per R beats.
module cic_dsm_decimator
   import cic_pkg::*;
#(
   parameter int IN_WIDTH  = 4,
   parameter int OUT_WIDTH = 16,
   parameter int N         = CIC_N_DEF,
   parameter int R         = CIC_R_DEF
) (
   input  logic                 aclk,
   input  logic                 arst_n,
   input  logic [IN_WIDTH-1:0]  s_axis_data_tdata,
   input  logic                 s_axis_data_tvalid,
   output logic                 s_axis_data_tready,
   output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
   output logic                 m_axis_data_tvalid,
   input  logic                 m_axis_data_tready
);

   localparam int ACC_W = cic_acc_width(IN_WIDTH, N, R);
   localparam int CNT_W = $clog2(R);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // ------------------------------------------------------------
   // Handshake and phase counter
   // ------------------------------------------------------------
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_tvalid;
   logic [OUT_WIDTH-1:0] r_tdata;

   logic w_last;
   logic w_s_ready;
   logic w_beat;
   logic w_dec;

   assign w_last = (r_cnt == CNT_LAST);

   // Stall only when the next beat would be a decimation event
   // and the previous sample is still waiting downstream.
   assign w_s_ready = !(r_tvalid && !m_axis_data_tready && w_last);
   assign w_beat    = s_axis_data_tvalid && w_s_ready;
   assign w_dec     = w_beat && w_last;

   // R is a power of two, so the counter wraps on its own.
   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         r_cnt <= '0;
      end else if (w_beat) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // ------------------------------------------------------------
   // Input mapping and sign extension to the accumulator width
   // ------------------------------------------------------------
   logic [ACC_W-1:0] w_x;

   if (IN_WIDTH == 1) begin : g_bits
      cic_pm1_t w_pm;
      assign w_pm = cic_bit_to_pm1(s_axis_data_tdata[0]);
      assign w_x  = {{(ACC_W-CIC_MIN_EW){w_pm[CIC_MIN_EW-1]}}, w_pm};
   end else begin : g_word
      assign w_x = {{(ACC_W-IN_WIDTH){s_axis_data_tdata[IN_WIDTH-1]}},
                    s_axis_data_tdata};
   end

   // ------------------------------------------------------------
   // Integrators: w_int[0] is the input, w_int[k] is stage k.
   // All stages read pre-update values, so they advance in lockstep.
   // ------------------------------------------------------------
   logic [ACC_W-1:0] w_int [N+1];

   assign w_int[0] = w_x;

   for (genvar k = 0; k < N; k++) begin : g_int
      logic [ACC_W-1:0] r_acc;

      always_ff @(posedge aclk) begin
         if (!arst_n) begin
            r_acc <= '0;
         end else if (w_beat) begin
            r_acc <= r_acc + w_int[k];
         end
      end

      assign w_int[k+1] = r_acc;
   end

   // ------------------------------------------------------------
   // Combs: evaluated on the pre-update last integrator and
   // clocked only on decimation events.
   // ------------------------------------------------------------
   logic [ACC_W-1:0] w_cmb [N+1];

   assign w_cmb[0] = w_int[N];

   for (genvar k = 0; k < N; k++) begin : g_cmb
      cic_comb_stage #(
         .W (ACC_W)
      ) u_comb (
         .i_clk   (aclk),
         .i_rst_n (arst_n),
         .i_en    (w_dec),
         .i_x     (w_cmb[k]),
         .o_y     (w_cmb[k+1])
      );
   end

   // ------------------------------------------------------------
   // Output scaling: sign-extend when wide enough, otherwise keep
   // the top bits (floor toward -inf).
   // ------------------------------------------------------------
   logic [OUT_WIDTH-1:0] w_scaled;

   if (OUT_WIDTH > ACC_W) begin : g_ext
      assign w_scaled = {{(OUT_WIDTH-ACC_W){w_cmb[N][ACC_W-1]}},
                         w_cmb[N]};
   end else if (OUT_WIDTH == ACC_W) begin : g_eq
      assign w_scaled = w_cmb[N];
   end else begin : g_trunc
      logic [ACC_W-OUT_WIDTH-1:0] w_drop;
      assign w_scaled = w_cmb[N][ACC_W-1 -: OUT_WIDTH];
      assign w_drop   = w_cmb[N][ACC_W-OUT_WIDTH-1:0];
   end

   // ------------------------------------------------------------
   // Output register. A decimation event on a handshake edge
   // reloads in place, so back-to-back delivery loses nothing.
   // ------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
      end else if (w_dec) begin
         r_tdata  <= w_scaled;
         r_tvalid <= 1'b1;
      end else if (m_axis_data_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign s_axis_data_tready = w_s_ready;
   assign m_axis_data_tdata  = r_tdata;
   assign m_axis_data_tvalid = r_tvalid;

endmodule

// File: tb/tb_cic_dsm_decimator.sv
// Randomized bench for cic_dsm_decimator (word and bitstream modes).
// Reference: closed-form CIC response built from binomial weights.
module tb_cic_dsm_decimator;

   localparam int N    = 3;
   localparam int R    = 16;
   localparam int OW   = 16;
   localparam int ACC0 = 4 + N * 4;
   localparam int ACC1 = 2 + N * 4;

   logic aclk = 1'b0;
   logic arst_n;

   always #5 aclk = ~aclk;

   logic [3:0]    s_d0;
   logic          s_v0, s_r0, m_v0, m_r0;
   logic [OW-1:0] m_d0;

   logic [0:0]    s_d1;
   logic          s_v1, s_r1, m_v1, m_r1;
   logic [OW-1:0] m_d1;

   cic_dsm_decimator #(
      .IN_WIDTH (4), .OUT_WIDTH (OW), .N (N), .R (R)
   ) u_dut0 (
      .aclk               (aclk),
      .arst_n             (arst_n),
      .s_axis_data_tdata  (s_d0),
      .s_axis_data_tvalid (s_v0),
      .s_axis_data_tready (s_r0),
      .m_axis_data_tdata  (m_d0),
      .m_axis_data_tvalid (m_v0),
      .m_axis_data_tready (m_r0)
   );

   cic_dsm_decimator #(
      .IN_WIDTH (1), .OUT_WIDTH (OW), .N (N), .R (R)
   ) u_dut1 (
      .aclk               (aclk),
      .arst_n             (arst_n),
      .s_axis_data_tdata  (s_d1),
      .s_axis_data_tvalid (s_v1),
      .s_axis_data_tready (s_r1),
      .m_axis_data_tdata  (m_d1),
      .m_axis_data_tvalid (m_v1),
      .m_axis_data_tready (m_r1)
   );

   int     n_cmp = 0;
   int     n_bad = 0;
   longint hist [2][$];
   longint expq [2][$];
   longint got  [2][$];
   int     gcyc [2][$];
   int     beats [2];
   int     cycle = 0;
   longint first_p1 = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint binom(input longint n, input int k);
      longint r;
      r = 1;
      if (n < k) return 0;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   // N-fold running sum of the accepted inputs before index t.
   function automatic longint run_sum(input int id, input int t);
      longint s;
      s = 0;
      for (int i = 0; i < t; i++)
         s += hist[id][i] * binom(t - 1 - i, N - 1);
      return s;
   endfunction

   // Output m (1-based): N-th difference of the running sums taken
   // every R beats, reduced modulo the accumulator width, scaled.
   function automatic longint ref_out(input int id, input int m);
      int     accw, t;
      longint acc, modv, v;
      accw = (id == 0) ? ACC0 : ACC1;
      acc  = 0;
      for (int k = 0; k <= N; k++) begin
         t = (m - k) * R - 1;
         if (t >= 0)
            acc += ((k % 2) ? -1 : 1) * binom(N, k) * run_sum(id, t);
      end
      modv = longint'(1) << accw;
      v = acc & (modv - 1);
      if (v >= modv / 2) v -= modv;
      if (accw > OW) v = v >>> (accw - OW);
      return v;
   endfunction

   task automatic tick();
      bit     v [2], rr [2], sr [2], mv [2];
      longint md [2], xx [2];
      bit     er;
      #1;
      v[0] = s_v0; rr[0] = m_r0; sr[0] = s_r0; mv[0] = m_v0;
      md[0] = longint'($signed(m_d0));
      xx[0] = longint'($signed(s_d0));
      v[1] = s_v1; rr[1] = m_r1; sr[1] = s_r1; mv[1] = m_v1;
      md[1] = longint'($signed(m_d1));
      xx[1] = s_d1[0] ? 1 : -1;
      for (int id = 0; id < 2; id++) begin
         er = !(expq[id].size() > 0 && !rr[id] && (beats[id] % R) == R - 1);
         chk($sformatf("s_tready%0d c%0d", id, cycle), sr[id], er);
         chk($sformatf("m_tvalid%0d c%0d", id, cycle), mv[id],
             expq[id].size() > 0);
         if (mv[id] && expq[id].size() > 0)
            chk($sformatf("m_tdata%0d c%0d", id, cycle), md[id], expq[id][0]);
         if (!arst_n) begin
            hist[id].delete();
            expq[id].delete();
            beats[id] = 0;
         end else begin
            if (mv[id] && rr[id] && expq[id].size() > 0) begin
               got[id].push_back(md[id]);
               gcyc[id].push_back(cycle);
               void'(expq[id].pop_front());
            end
            if (v[id] && sr[id]) begin
               hist[id].push_back(xx[id]);
               if (beats[id] % R == R - 1)
                  expq[id].push_back(ref_out(id, (beats[id] + 1) / R));
               beats[id]++;
            end
         end
      end
      cycle++;
      @(negedge aclk);
   endtask

   // mode 0: constant val, 1: alternating 1/0, 2: random
   task automatic run(input int id, input int ncyc, input int mode,
                      input int val, input int vpct, input int rpct);
      logic       vv, rdy;
      logic [3:0] dd;
      bit         alt;
      alt = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         vv  = ($urandom_range(99) < vpct);
         rdy = ($urandom_range(99) < rpct);
         case (mode)
            0:       dd = 4'(val);
            1:       dd = {3'b0, alt};
            default: dd = 4'($urandom);
         endcase
         alt = ~alt;
         if (id == 0) begin
            s_v0 = vv; s_d0 = dd; m_r0 = rdy; s_v1 = 1'b0; m_r1 = 1'b1;
         end else begin
            s_v1 = vv; s_d1 = dd[0]; m_r1 = rdy; s_v0 = 1'b0; m_r0 = 1'b1;
         end
         tick();
      end
   endtask

   task automatic do_reset();
      s_v0 = 1'b0; m_r0 = 1'b1; s_v1 = 1'b0; m_r1 = 1'b1;
      arst_n = 1'b0;
      tick();
      arst_n = 1'b1;
      for (int id = 0; id < 2; id++) begin
         got[id].delete();
         gcyc[id].delete();
      end
   endtask

   task automatic steady(input int id, input longint exp, input string tag);
      chk({tag, "_n"}, got[id].size() >= 6, 1);
      for (int i = 4; i < got[id].size(); i++)
         chk($sformatf("%s[%0d]", tag, i), got[id][i], exp);
   endtask

   initial begin
      arst_n = 1'b0;
      s_d0 = '0; s_v0 = 1'b0; m_r0 = 1'b1;
      s_d1 = '0; s_v1 = 1'b0; m_r1 = 1'b1;
      beats[0] = 0; beats[1] = 0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      do_reset();
      chk("rst_tvalid", m_v0, 0);
      chk("rst_tdata", longint'(m_d0), 0);
      chk("rst_tready", s_r0, 1);

      // Constant +1: eight outputs, 16 clocks apart, settled at 4096.
      run(0, 128, 0, 1, 100, 100);
      run(0, 4, 0, 0, 0, 100);
      chk("p1_count", got[0].size(), 8);
      if (got[0].size() > 0) begin
         first_p1 = got[0][0];
         chk("p1_first", got[0][0], 455);
      end
      for (int i = 1; i < gcyc[0].size(); i++)
         chk($sformatf("p1_gap[%0d]", i), gcyc[0][i] - gcyc[0][i-1], 16);
      steady(0, 4096, "p1");

      do_reset();
      run(0, 128, 0, -8, 100, 100);
      run(0, 4, 0, 0, 0, 100);
      steady(0, -32768, "neg8");

      do_reset();
      run(0, 128, 0, 7, 100, 100);
      run(0, 4, 0, 0, 0, 100);
      steady(0, 28672, "pos7");

      // Backpressure from output 3 onward.
      do_reset();
      begin
         int     c;
         longint held;
         c = 0;
         s_v1 = 1'b0; m_r1 = 1'b1;
         while (got[0].size() < 2 && c < 300) begin
            s_v0 = 1'b1; s_d0 = 4'($urandom); m_r0 = 1'b1;
            tick();
            c++;
         end
         chk("bp_reach", got[0].size(), 2);
         for (int i = 0; i < 60; i++) begin
            s_v0 = 1'b1; s_d0 = 4'($urandom); m_r0 = 1'b0;
            tick();
         end
         chk("bp_cnt", beats[0] % R, R - 1);
         chk("bp_tready", s_r0, 0);
         chk("bp_tvalid", m_v0, 1);
         held = longint'($signed(m_d0));
         m_r0 = 1'b1;
         tick();
         chk("bp_n", got[0].size(), 3);
         if (got[0].size() > 2) chk("bp_held", got[0][2], held);
         run(0, 200, 2, 0, 100, 100);
      end

      // Gapped input, constant +2.
      do_reset();
      run(0, 500, 0, 2, 50, 100);
      run(0, 4, 0, 0, 0, 100);
      steady(0, 8192, "gap");
      chk("gap_count", got[0].size(), beats[0] / R);

      // Reset at beat 40 of a +1 stream.
      do_reset();
      run(0, 40, 0, 1, 100, 100);
      chk("mid_beats", beats[0], 40);
      s_v0 = 1'b1; s_d0 = 4'd1;
      arst_n = 1'b0;
      tick();
      arst_n = 1'b1;
      got[0].delete();
      gcyc[0].delete();
      chk("mid_tvalid", m_v0, 0);
      run(0, 16, 0, 1, 100, 100);
      chk("mid_early", got[0].size(), 0);
      run(0, 1, 0, 1, 100, 100);
      chk("mid_count", got[0].size(), 1);
      if (got[0].size() > 0) chk("mid_first", got[0][0], first_p1);

      // Random data, valid and ready.
      do_reset();
      run(0, 800, 2, 0, 70, 70);
      run(0, 4, 0, 0, 0, 100);
      chk("rand_count", got[0].size(), beats[0] / R);

      // Bitstream mode.
      do_reset();
      run(1, 128, 0, 1, 100, 100);
      run(1, 4, 0, 0, 0, 100);
      steady(1, 4096, "bs_ones");

      do_reset();
      run(1, 128, 1, 0, 100, 100);
      run(1, 4, 0, 0, 0, 100);
      steady(1, 0, "bs_alt");

      do_reset();
      run(1, 400, 2, 0, 80, 80);
      run(1, 4, 0, 0, 0, 100);
      chk("bs_rand_count", got[1].size(), beats[1] / R);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
